pwm_fre_sweep_ctrl: RTL and testbench

- Sequencer that drives the 20-bit `fre` input of the push-PWM frequency generator through a programmable linear sweep.
- Sweep runs from fre_start to fre_end in fre_step increments, holding each value for dwell_cycles clocks.
- Replaces hand-timed frequency stepping with a hardware scheduler.
- Sits between the register/config logic and the PWM generator.

---
 rtl/pwm_fre_sweep_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pwm_fre_sweep_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_fre_sweep_ctrl.sv
// Linear frequency sweep sequencer that drives the PWM generator's fre word.
// Define PWM_SWEEP_TRIANGLE_EN to add dir_tri for an up-then-down (triangle) sweep.
module pwm_fre_sweep_ctrl #(
    parameter int FRE_W   = 20,
    parameter int DWELL_W = 16,
    parameter int CNT_W   = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
    input  logic [FRE_W-1:0]   fre_start,
    input  logic [FRE_W-1:0]   fre_step,
    input  logic [FRE_W-1:0]   fre_end,
    input  logic [DWELL_W-1:0] dwell_cycles,
`ifdef PWM_SWEEP_TRIANGLE_EN
    input  logic               dir_tri,
`endif
    output logic [FRE_W-1:0]   fre,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   step_idx
);

    // STEP is never registered: the step decision is resolved in the DWELL expiry cycle.
    typedef enum logic [1:0] {IDLE, DWELL, STEP, FIN} state_t;

    state_t             state, state_nx;
    logic [FRE_W-1:0]   cfg_start, cfg_step, cfg_end;
    logic [DWELL_W-1:0] cfg_dwell;
    logic               cfg_loop;
    logic               latch;
    logic [DWELL_W-1:0] cnt, cnt_nx;
    logic [FRE_W-1:0]   fre_nx;
    logic               busy_nx, done_nx;
    logic [CNT_W-1:0]   idx_nx, idx_inc;
    logic [FRE_W:0]     up_sum;
    logic               up_end, descending;

    function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
        return (d == '0) ? '0 : d - 1'b1;
    endfunction

    assign up_sum  = {1'b0, fre} + {1'b0, cfg_step};
    assign up_end  = (cfg_step == '0) || up_sum[FRE_W] || (up_sum > {1'b0, cfg_end});
    assign idx_inc = (step_idx == '1) ? step_idx : step_idx + 1'b1;

`ifdef PWM_SWEEP_TRIANGLE_EN
    logic           cfg_tri, down, down_nx;
    logic [FRE_W:0] dn_dif;
    logic           dn_end;

    // A borrow or landing below fre_start ends the descent.
    assign dn_dif     = {1'b0, fre} - {1'b0, cfg_step};
    assign dn_end     = (cfg_step == '0) || dn_dif[FRE_W] || (dn_dif[FRE_W-1:0] < cfg_start);
    assign descending = down;
`else
    assign descending = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        fre_nx   = fre;
        busy_nx  = busy;
        done_nx  = 1'b0;
        idx_nx   = step_idx;
        cnt_nx   = cnt;
        latch    = 1'b0;
`ifdef PWM_SWEEP_TRIANGLE_EN
        down_nx  = down;
`endif
        case (state)
            IDLE, FIN: begin
                state_nx = IDLE;
                if (start) begin
                    latch    = 1'b1;
                    state_nx = DWELL;
                    fre_nx   = fre_start;
                    busy_nx  = 1'b1;
                    idx_nx   = '0;
                    cnt_nx   = dwell_load(dwell_cycles);
`ifdef PWM_SWEEP_TRIANGLE_EN
                    down_nx  = 1'b0;
`endif
                end
            end
            DWELL: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - 1'b1;
                end else if (!descending && !up_end) begin
                    fre_nx = up_sum[FRE_W-1:0];
                    idx_nx = idx_inc;
                    cnt_nx = dwell_load(cfg_dwell);
`ifdef PWM_SWEEP_TRIANGLE_EN
                end else if (cfg_tri && !dn_end) begin
                    down_nx = 1'b1;
                    fre_nx  = dn_dif[FRE_W-1:0];
                    idx_nx  = idx_inc;
                    cnt_nx  = dwell_load(cfg_dwell);
`endif
                end else if (cfg_loop) begin
                    // End of pass in loop mode: restart without a gap cycle.
                    done_nx = 1'b1;
                    fre_nx  = cfg_start;
                    idx_nx  = '0;
                    cnt_nx  = dwell_load(cfg_dwell);
`ifdef PWM_SWEEP_TRIANGLE_EN
                    down_nx = 1'b0;
`endif
                end else begin
                    done_nx  = 1'b1;
                    busy_nx  = 1'b0;
                    state_nx = FIN;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (stop) begin
            state_nx = IDLE;
            fre_nx   = fre;
            busy_nx  = 1'b0;
            done_nx  = 1'b0;
            idx_nx   = step_idx;
            cnt_nx   = cnt;
            latch    = 1'b0;
`ifdef PWM_SWEEP_TRIANGLE_EN
            down_nx  = down;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            fre       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            step_idx  <= '0;
            cnt       <= '0;
            cfg_start <= '0;
            cfg_step  <= '0;
            cfg_end   <= '0;
            cfg_dwell <= '0;
            cfg_loop  <= 1'b0;
`ifdef PWM_SWEEP_TRIANGLE_EN
            cfg_tri   <= 1'b0;
            down      <= 1'b0;
`endif
        end else begin
            state    <= state_nx;
            fre      <= fre_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            step_idx <= idx_nx;
            cnt      <= cnt_nx;
`ifdef PWM_SWEEP_TRIANGLE_EN
            down     <= down_nx;
`endif
            if (latch) begin
                cfg_start <= fre_start;
                cfg_step  <= fre_step;
                cfg_end   <= fre_end;
                cfg_dwell <= dwell_cycles;
                cfg_loop  <= loop_en;
`ifdef PWM_SWEEP_TRIANGLE_EN
                cfg_tri   <= dir_tri;
`endif
            end
        end
    end

endmodule

// File: tb/tb_pwm_fre_sweep_ctrl.sv
// Scoreboard bench for pwm_fre_sweep_ctrl: expected (fre, hold, step_idx) segments are
// queued at start and matched against the observed output runs.
module tb_pwm_fre_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic [19:0] fre_start = '0;
    logic [19:0] fre_step = '0;
    logic [19:0] fre_end = '0;
    logic [15:0] dwell_cycles = '0;
`ifdef PWM_SWEEP_TRIANGLE_EN
    logic        dir_tri = 1'b0;
`endif
    logic [19:0] fre;
    logic        busy;
    logic        done;
    logic [11:0] step_idx;

    typedef struct {
        logic [19:0] fre;
        int          hold;
        logic [11:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   exp_total;
    int   vectors = 0;
    int   miscompares = 0;

    pwm_fre_sweep_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .loop_en      (loop_en),
        .fre_start    (fre_start),
        .fre_step     (fre_step),
        .fre_end      (fre_end),
        .dwell_cycles (dwell_cycles),
`ifdef PWM_SWEEP_TRIANGLE_EN
        .dir_tri      (dir_tri),
`endif
        .fre          (fre),
        .busy         (busy),
        .done         (done),
        .step_idx     (step_idx)
    );

    always #5 clk = ~clk;

    // Push the expected sequence of held values for one pass.
    task automatic expect_ramp(input int s, input int sp, input int e, input int d, input bit tri_en);
        exp_t x;
        int   v, n, idx, hold;
        hold = (d == 0) ? 1 : d;
        v = s; idx = 0; exp_total = 0;
        forever begin
            x.fre = 20'(v); x.hold = hold; x.idx = 12'((idx > 4095) ? 4095 : idx);
            exp_q.push_back(x); exp_total += hold; idx++;
            n = v + sp;
            if (sp == 0 || n > e || n > 'hFFFFF) break;
            v = n;
        end
        if (tri_en && sp != 0) begin
            n = v - sp;
            while (n >= s) begin
                x.fre = 20'(n); x.hold = hold; x.idx = 12'((idx > 4095) ? 4095 : idx);
                exp_q.push_back(x); exp_total += hold; idx++;
                n = n - sp;
            end
        end
    endtask

    // Pulse start with a config, then scramble the config inputs.
    task automatic kick(input logic [19:0] s, input logic [19:0] sp, input logic [19:0] e,
                        input logic [15:0] d, input logic lp);
        fre_start = s; fre_step = sp; fre_end = e; dwell_cycles = d; loop_en = lp;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fre_start = 20'($urandom); fre_step = 20'($urandom); fre_end = 20'($urandom);
        dwell_cycles = 16'($urandom); loop_en = ~lp;
    endtask

    // Watch one pass from its first cycle until done; optionally pulse start at cycle 'poke'.
    task automatic collect(input string nm, input int budget, input int poke, output int cyc);
        logic [19:0] cur;
        logic [11:0] cidx;
        int          len;
        exp_t        e;
        cur = fre; cidx = step_idx; len = 1; cyc = 1;
        start = (poke == 0);
        @(negedge clk);
        while (cyc < budget) begin
            if (done || fre !== cur || step_idx !== cidx) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL %s seg: unexpected fre=%0d idx=%0d len=%0d", nm, cur, cidx, len);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e.fre || len !== e.hold || cidx !== e.idx) begin
                        miscompares++;
                        $display("FAIL %s seg: got fre=%0d idx=%0d len=%0d, want fre=%0d idx=%0d len=%0d",
                                 nm, cur, cidx, len, e.fre, e.idx, e.hold);
                    end
                end
                if (done) break;
                cur = fre; cidx = step_idx; len = 0;
            end
            start = (cyc == poke);
            len++; cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL %s timeout: no done within %0d cycles", nm, budget);
        end
    endtask

    task automatic check_end(input string nm, input logic [19:0] last, input int cyc);
        vectors++;
        if (cyc !== exp_total) begin
            miscompares++; $display("FAIL %s pass_len: got %0d want %0d", nm, cyc, exp_total);
        end
        vectors++;
        if (busy !== 1'b0 || fre !== last) begin
            miscompares++; $display("FAIL %s at_done: busy=%0b fre=%0d want busy=0 fre=%0d", nm, busy, fre, last);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || fre !== last) begin
            miscompares++; $display("FAIL %s after_done: done=%0b busy=%0b fre=%0d want 0/0/%0d", nm, done, busy, fre, last);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++; $display("FAIL %s leftover: %0d segments not seen, want 0", nm, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (fre !== 20'd0 || busy !== 1'b0 || done !== 1'b0 || step_idx !== 12'd0) begin
            miscompares++;
            $display("FAIL reset: fre=%0d busy=%0b done=%0b idx=%0d want all 0", fre, busy, done, step_idx);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || fre !== 20'd0) begin
            miscompares++; $display("FAIL reset_idle: busy=%0b fre=%0d want 0/0", busy, fre);
        end
    endtask

    task automatic test_single_pass();
        int cyc;
        expect_ramp(160, 160, 1600, 100, 1'b0);
        kick(20'd160, 20'd160, 20'd1600, 16'd100, 1'b0);
        collect("single", 1100, -1, cyc);
        check_end("single", 20'd1600, cyc);
    endtask

    task automatic test_zero_step();
        int cyc;
        expect_ramp(500, 0, 1000, 0, 1'b0);
        kick(20'd500, 20'd0, 20'd1000, 16'd0, 1'b0);
        collect("zero_step", 20, -1, cyc);
        check_end("zero_step", 20'd500, cyc);
    endtask

    task automatic test_start_gt_end();
        int cyc;
        expect_ramp(2000, 160, 1000, 100, 1'b0);
        kick(20'd2000, 20'd160, 20'd1000, 16'd100, 1'b0);
        collect("start_gt_end", 200, -1, cyc);
        check_end("start_gt_end", 20'd2000, cyc);
    endtask

    task automatic test_overflow();
        int cyc;
        expect_ramp('hFFF00, 'h80, 'hFFFFF, 3, 1'b0);
        kick(20'hFFF00, 20'h80, 20'hFFFFF, 16'd3, 1'b0);
        collect("overflow", 50, -1, cyc);
        check_end("overflow", 20'hFFF80, cyc);
    endtask

    task automatic test_start_stop_idle();
        fre_start = 20'd777; fre_step = 20'd1; fre_end = 20'd900; dwell_cycles = 16'd5;
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        vectors++;
        if (busy !== 1'b0 || fre !== 20'hFFF80 || done !== 1'b0) begin
            miscompares++; $display("FAIL start_stop: busy=%0b fre=%0d done=%0b want 0/%0d/0", busy, fre, done, 20'hFFF80);
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || fre !== 20'hFFF80) begin
            miscompares++; $display("FAIL start_stop_later: busy=%0b fre=%0d want 0/%0d", busy, fre, 20'hFFF80);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        expect_ramp(10, 10, 50, 5, 1'b0);
        kick(20'd10, 20'd10, 20'd50, 16'd5, 1'b0);
        collect("start_busy", 60, 7, cyc);
        check_end("start_busy", 20'd50, cyc);
    endtask

    task automatic test_loop();
        int cyc;
        expect_ramp(160, 160, 1600, 100, 1'b0);
        kick(20'd160, 20'd160, 20'd1600, 16'd100, 1'b1);
        for (int p = 0; p < 2; p++) begin
            expect_ramp(160, 160, 1600, 100, 1'b0);
            collect("loop", 1100, -1, cyc);
            vectors++;
            if (cyc !== 1000 || busy !== 1'b1 || fre !== 20'd160 || step_idx !== 12'd0) begin
                miscompares++;
                $display("FAIL loop_wrap%0d: len=%0d busy=%0b fre=%0d idx=%0d want 1000/1/160/0", p, cyc, busy, fre, step_idx);
            end
        end
        exp_q.delete();
        repeat (500) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        vectors++;
        if (busy !== 1'b0 || fre !== 20'd960 || done !== 1'b0 || step_idx !== 12'd5) begin
            miscompares++;
            $display("FAIL loop_stop: busy=%0b fre=%0d done=%0b idx=%0d want 0/960/0/5", busy, fre, done, step_idx);
        end
        repeat (20) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || fre !== 20'd960 || done !== 1'b0) begin
            miscompares++; $display("FAIL loop_frozen: busy=%0b fre=%0d done=%0b want 0/960/0", busy, fre, done);
        end
    endtask

    task automatic test_saturate();
        int cyc;
        expect_ramp(0, 1, 5000, 0, 1'b0);
        kick(20'd0, 20'd1, 20'd5000, 16'd0, 1'b0);
        collect("saturate", 6000, -1, cyc);
        vectors++;
        if (step_idx !== 12'hFFF) begin
            miscompares++; $display("FAIL saturate_idx: got %0d want 4095", step_idx);
        end
        check_end("saturate", 20'd5000, cyc);
    endtask

`ifdef PWM_SWEEP_TRIANGLE_EN
    task automatic test_triangle();
        int cyc;
        expect_ramp(160, 160, 640, 4, 1'b1);
        dir_tri = 1'b1;
        kick(20'd160, 20'd160, 20'd640, 16'd4, 1'b0);
        dir_tri = 1'b0;
        collect("triangle", 100, -1, cyc);
        check_end("triangle", 20'd160, cyc);
    endtask
`endif

    task automatic test_reset_mid();
        kick(20'd160, 20'd160, 20'd1600, 16'd100, 1'b0);
        repeat (250) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (fre !== 20'd0 || busy !== 1'b0 || step_idx !== 12'd0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: fre=%0d busy=%0b idx=%0d done=%0b want all 0", fre, busy, step_idx, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        vectors++;
        if (fre !== 20'd0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_mid_after: fre=%0d busy=%0b want 0/0", fre, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_zero_step();
        test_start_gt_end();
        test_overflow();
        test_start_stop_idle();
        test_back_to_back();
        test_loop();
        test_saturate();
`ifdef PWM_SWEEP_TRIANGLE_EN
        test_triangle();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
